// File: rtl/morse_input_conditioner.sv
// Conditions two Morse keys and a "done" switch: synchronize, debounce, edge-detect,
// then sequence dot/dash/done strobes and track the symbols of the current character.
module morse_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int GAP_CYCLES      = 75000000,
  parameter bit AUTO_DONE_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] button_n,
  input  logic [3:0] switch_in,
  output logic       dot_pulse,
  output logic       dash_pulse,
  output logic       done_pulse,
  output logic       err_pulse,
  output logic [2:0] sym_count,
  output logic       busy
);

  localparam int DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GW  = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]     SYM_MAX  = 3'd5;

  typedef enum logic [0:0] {IDLE, COLLECT} state_e;

  // Channel order in the 3-bit vectors: [0]=dot, [1]=dash, [2]=done switch.
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     level;
  logic [2:0]     stable_q, stable_d;
  logic [DBW-1:0] db_cnt_q [3];
  logic [DBW-1:0] db_cnt_d [3];
  logic [2:0]     press_ev;

  logic unused_switches;
  assign unused_switches = ^switch_in[3:1];

  // Raw (not yet inverted) levels are synchronized, so key stages idle at 1.
  assign level = {sync2_q[2], ~sync2_q[1:0]};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can be inferred.
    stable_d = stable_q;
    press_ev = '0;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (level[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
          press_ev[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 3'b011;
      sync2_q  <= 3'b011;
      stable_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sync1_q  <= {switch_in[0], button_n};
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  state_e        state_q, state_d;
  logic [2:0]    sym_q, sym_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pend_q, pend_d;
  logic          dot_q, dot_d, dash_q, dash_d, done_q, done_d, err_q, err_d;
  logic          dot_ev, dash_ev, done_ev, sym_ev, accepted;

  assign dot_ev  = press_ev[0];
  assign dash_ev = press_ev[1];
  assign done_ev = press_ev[2];
  assign sym_ev  = dot_ev | dash_ev;

  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    gap_d    = gap_q;
    pend_d   = 1'b0;
    dot_d    = 1'b0;
    dash_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    accepted = 1'b0;
    if (pend_q) begin
      // Deferred done from a symbol+done collision; any event landing here is dropped.
      done_d  = 1'b1;
      sym_d   = '0;
      gap_d   = '0;
      state_d = IDLE;
      err_d   = |press_ev;
    end else begin
      if (dot_ev && dash_ev) begin
        err_d = 1'b1;
      end else if (sym_ev) begin
        if (sym_q < SYM_MAX) begin
          accepted = 1'b1;
          dot_d    = dot_ev;
          dash_d   = dash_ev;
          sym_d    = sym_q + 3'd1;
          gap_d    = '0;
          state_d  = COLLECT;
          pend_d   = done_ev;
        end else begin
          err_d = 1'b1;
        end
      end
      if (!accepted) begin
        if (done_ev) begin
          if (state_q == COLLECT) begin
            done_d  = 1'b1;
            sym_d   = '0;
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            err_d = 1'b1;
          end
        end else if (AUTO_DONE_EN && state_q == COLLECT && !sym_ev) begin
          if (gap_q == GAP_LAST) begin
            done_d  = 1'b1;
            sym_d   = '0;
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sym_q   <= '0;
      gap_q   <= '0;
      pend_q  <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      gap_q   <= gap_d;
      pend_q  <= pend_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign dot_pulse  = dot_q;
  assign dash_pulse = dash_q;
  assign done_pulse = done_q;
  assign err_pulse  = err_q;
  assign sym_count  = sym_q;
  assign busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_morse_input_conditioner.sv
// Directed bench for morse_input_conditioner with short debounce (4) and gap (20) windows.
module tb_morse_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] button_n = 2'b11;
  logic [3:0] switch_in = 4'b0000;
  logic       dot_pulse, dash_pulse, done_pulse, err_pulse, busy;
  logic [2:0] sym_count;

  morse_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .GAP_CYCLES     (20),
    .AUTO_DONE_EN   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .button_n  (button_n),
    .switch_in (switch_in),
    .dot_pulse (dot_pulse),
    .dash_pulse(dash_pulse),
    .done_pulse(done_pulse),
    .err_pulse (err_pulse),
    .sym_count (sym_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dots = 0, dashes = 0, dones = 0, errs = 0, overlaps = 0;
  int d0, a0, n0, e0;

  // Strobes are tallied mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (dot_pulse)  dots++;
    if (dash_pulse) dashes++;
    if (done_pulse) dones++;
    if (err_pulse)  errs++;
    if ((dot_pulse && dash_pulse) || (done_pulse && (dot_pulse || dash_pulse))) overlaps++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int which, input bit on);
    case (which)
      0:       button_n[0] = ~on;
      1:       button_n[1] = ~on;
      default: switch_in[0] = on;
    endcase
  endtask

  task automatic press(input int which);
    drive(which, 1'b1);
    tick(8);
    drive(which, 1'b0);
    tick(8);
  endtask

  task automatic snap();
    d0 = dots;
    a0 = dashes;
    n0 = dones;
    e0 = errs;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dot"},  dot_pulse,  0);
    check({tag, "_dash"}, dash_pulse, 0);
    check({tag, "_done"}, done_pulse, 0);
    check({tag, "_err"},  err_pulse,  0);
    check({tag, "_sym"},  sym_count,  0);
    check({tag, "_busy"}, busy,       0);
  endtask

  initial begin
    // Reset state
    tick(3);
    check_quiet("reset");
    rst_n = 1'b1;
    switch_in[3:1] = 3'b101;
    tick(2);

    // One held dot: pulse at edge 6, auto done 20 edges later
    snap();
    drive(0, 1'b1);
    for (int k = 1; k <= 27; k++) begin
      tick();
      check("t1_dot", dot_pulse, (k == 6));
      check("t1_done", done_pulse, (k == 26));
      if (k == 6) begin
        check("t1_sym", sym_count, 1);
        check("t1_busy", busy, 1);
      end
      if (k == 10) drive(0, 1'b0);
    end
    check("t1_sym_end", sym_count, 0);
    check("t1_busy_end", busy, 0);
    check("t1_errs", errs - e0, 0);
    tick(5);

    // Three-cycle glitch is ignored
    snap();
    drive(0, 1'b1);
    tick(3);
    drive(0, 1'b0);
    tick(12);
    check("glitch_dots", dots - d0, 0);
    check("glitch_sym", sym_count, 0);
    check("glitch_errs", errs - e0, 0);

    // dash, dot, dot, then done switch
    snap();
    press(1);
    check("seq_dash", dashes - a0, 1);
    check("seq_sym1", sym_count, 1);
    press(0);
    check("seq_sym2", sym_count, 2);
    press(0);
    check("seq_dots", dots - d0, 2);
    check("seq_sym3", sym_count, 3);
    check("seq_busy3", busy, 1);
    press(2);
    check("seq_done", dones - n0, 1);
    check("seq_sym_end", sym_count, 0);
    check("seq_busy_end", busy, 0);
    check("seq_errs", errs - e0, 0);

    // Dot and dash together are both dropped
    snap();
    button_n = 2'b00;
    tick(8);
    button_n = 2'b11;
    tick(8);
    check("both_errs", errs - e0, 1);
    check("both_dots", dots - d0, 0);
    check("both_dashes", dashes - a0, 0);
    check("both_sym", sym_count, 0);
    check("both_busy", busy, 0);

    // Six dots: the sixth overflows
    snap();
    repeat (5) press(0);
    check("six_sym5", sym_count, 5);
    drive(0, 1'b1);
    tick(6);
    check("six_err", err_pulse, 1);
    check("six_nodot", dot_pulse, 0);
    check("six_sym_hold", sym_count, 5);
    check("six_busy", busy, 1);
    drive(0, 1'b0);
    tick(30);
    check("six_dots", dots - d0, 5);
    check("six_errs", errs - e0, 1);
    check("six_autodone", dones - n0, 1);
    check("six_sym_end", sym_count, 0);

    // Dot and done in the same cycle at sym_count=2
    press(0);
    press(0);
    check("coll_sym2", sym_count, 2);
    snap();
    button_n[0] = 1'b0;
    switch_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("coll_dot", dot_pulse, (k == 6));
      check("coll_done", done_pulse, (k == 7));
      if (k == 6) check("coll_sym3", sym_count, 3);
      if (k == 7) check("coll_sym0", sym_count, 0);
    end
    button_n[0] = 1'b1;
    switch_in[0] = 1'b0;
    tick(10);
    check("coll_errs", errs - e0, 0);
    check("coll_busy", busy, 0);

    // Reset mid-character abandons it
    repeat (3) press(0);
    check("rst_sym3", sym_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("rst_async");
    snap();
    tick();
    rst_n = 1'b1;
    tick(30);
    check("rst_nodone", dones - n0, 0);
    check("rst_busy", busy, 0);

    // Key held through reset release yields one press
    snap();
    drive(0, 1'b1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("hold_dot", dots - d0, 1);
    check("hold_sym", sym_count, 1);
    drive(0, 1'b0);
    tick(30);
    check("hold_dot_once", dots - d0, 1);
    check("hold_autodone", dones - n0, 1);

    // Done switch in IDLE is an error, not a done
    snap();
    press(2);
    check("idle_done_err", errs - e0, 1);
    check("idle_done_none", dones - n0, 0);
    check("idle_busy", busy, 0);

    check("no_overlap", overlaps, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/morse_input_conditioner.md
MORSE_INPUT_CONDITIONER -- requirements
Module: morse_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable cycles needed to accept an input change (20 ms at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 75000000, idle cycles after the last symbol before an automatic done (1.5 s at 50 MHz).
REQ-003 Parameter AUTO_DONE_EN, default 1, 1 enables the gap-timeout done.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 button_n  in  2  raw active-low keys, asynchronous; [0]=dot, [1]=dash.
REQ-007 switch_in  in  4  raw DIP switches, asynchronous; only [0] (done) is used, [3:1] ignored.
REQ-008 dot_pulse  out  1  one-cycle dot symbol strobe to the decoder.
REQ-009 dash_pulse  out  1  one-cycle dash symbol strobe.
REQ-010 done_pulse  out  1  one-cycle end-of-character strobe.
REQ-011 err_pulse  out  1  one-cycle strobe for a dropped or illegal input.
REQ-012 sym_count  out  3  symbols accepted in the current character, 0-5.
REQ-013 busy  out  1  high while the state is COLLECT.

Function
REQ-014 Each of the three raw inputs SHALL pass through a two-flop synchronizer; the button inputs are inverted so that 1 = pressed.
REQ-015 Each input SHALL have its own debounce counter and stable bit.
- Counter clears when the synchronized value equals the stable bit.
- Counter increments while they differ.
- Stable bit toggles and the counter clears when the counter reaches DEBOUNCE_CYCLES-1.
REQ-016 A raw level held constant SHALL produce its stable-bit change DEBOUNCE_CYCLES+2 edges after it is first sampled; a glitch shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-017 A press event SHALL be a 0->1 stable-bit transition, one cycle wide; releases and switch 1->0 transitions SHALL produce no event.
REQ-018 The FSM SHALL have two states, IDLE and COLLECT, with a 3-bit sym_count and a gap timer sized to GAP_CYCLES.
REQ-019 Single dot or dash event, sym_count<5: assert the matching pulse in the following cycle, increment sym_count, clear the gap timer, go to or stay in COLLECT.
REQ-020 Dot or dash event with sym_count==5: no symbol pulse, assert err_pulse, sym_count unchanged.
REQ-021 Dot and dash events in the same cycle: both dropped, err_pulse asserted, counters and state unchanged.
REQ-022 Done event in COLLECT: assert done_pulse next cycle, clear sym_count and gap timer, go to IDLE.
REQ-023 Done event in IDLE: no done_pulse, assert err_pulse.
REQ-024 Symbol and done events in the same cycle in IDLE or COLLECT: emit the symbol pulse first, then done_pulse exactly one cycle later via a pending flag. The done is never dropped, and no err_pulse is raised for it.
REQ-025 In COLLECT with AUTO_DONE_EN=1, the gap timer SHALL increment each cycle without an event; on reaching GAP_CYCLES-1, assert done_pulse next cycle, clear sym_count, go to IDLE.
REQ-026 With AUTO_DONE_EN=0, the gap timer SHALL hold at 0.
REQ-027 At most one of dot_pulse and dash_pulse SHALL be high in any cycle; done_pulse SHALL never coincide with a symbol pulse.
REQ-028 busy SHALL equal (state==COLLECT); sym_count SHALL be registered.

Reset
REQ-029 While rst_n=0, all outputs, pulses, counters, the pending flag and the gap timer SHALL be 0, and the state SHALL be IDLE.
REQ-030 Synchronizer flops and stable bits SHALL reset to the inactive level (button synchronizer stages to 1, post-inversion stable 0).
REQ-031 Reset asserted mid-character SHALL abandon that character with no done_pulse.
REQ-032 An input held active through reset release SHALL yield exactly one press event after debounce.

Verification (DEBOUNCE_CYCLES=4, GAP_CYCLES=20)
REQ-033 Dot key low for 10 cycles -> one dot_pulse at edge 6 after first sample; sym_count=1; busy=1.
REQ-034 Dot key 3-cycle glitch -> no pulse, sym_count stays 0.
REQ-035 Sequence dash, dot, dot, then switch[0] rises -> dash, dot, dot pulses, then done_pulse; sym_count=0; busy=0.
REQ-036 One dot, then no input -> done_pulse 20 cycles after the dot's last event; state IDLE.
REQ-037 Six dot presses -> five dot_pulses, sixth gives err_pulse; sym_count=5.
REQ-038 Dot event and done event in the same cycle while in COLLECT with sym_count=2 -> dot_pulse at cycle N, done_pulse at N+1, sym_count 3 then 0.
REQ-039 rst_n low for 1 cycle with sym_count=3 -> all outputs 0 immediately; no done_pulse afterwards.
